// File: rtl/msx_mouse_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : msx_mouse_port_ctrl
//  Purpose  : Shares MSX joystick port A between the host digital joystick
//             and the host mouse. In mouse mode it runs the MSX mouse nibble
//             protocol on the port strobe line. Host mouse movement is
//             accumulated between MSX reads.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT      idle clocks after the last strobe edge before the nibble
//                 phase returns to 0 (minimum 2)
//  Ports
//    clk21m       system clock
//    pSltRst_n    asynchronous active-low reset
//    joy_in       host joystick, active-low ([5:4] buttons, [3:0] directions)
//    mouse_x/y    host mouse deltas, 9-bit two's complement
//    mouse_flags  host mouse buttons, active-high ([0] left, [1] right)
//    mouse_strobe one-clock pulse, new delta valid on mouse_x/mouse_y
//    stra         MSX port A strobe (pin 8), same clock domain
//    port_o       pin level ([5:4] triggers, [3:0] nibble/directions)
//    port_oe      per-bit drive enable, set only where the level is 0
//    mouse_active 1 = mouse mode
//  Build option
//    MOUSE_ACCUM_EN  defined  : deltas accumulate with +/-1023 clamping
//                    undefined: each mouse_strobe overwrites the accumulators
// ============================================================================
module msx_mouse_port_ctrl #(
    parameter int TIMEOUT = 100000
) (
    input  logic       clk21m,
    input  logic       pSltRst_n,
    input  logic [5:0] joy_in,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic [1:0] mouse_flags,
    input  logic       mouse_strobe,
    input  logic       stra,
    output logic [5:0] port_o,
    output logic [5:0] port_oe,
    output logic       mouse_active
);

    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(1);

    // Nibble phase: which half of which byte the next strobe edge presents
    localparam logic [1:0] PH_XH = 2'd0;
    localparam logic [1:0] PH_XL = 2'd1;
    localparam logic [1:0] PH_YH = 2'd2;
    localparam logic [1:0] PH_YL = 2'd3;

    // Clamp an 11-bit signed accumulator to the byte range sent to the MSX
    function automatic logic [7:0] sat8(input logic signed [10:0] v);
        if (v > 11'sd127)       return 8'h7F;
        else if (v < -11'sd128) return 8'h80;
        else                    return v[7:0];
    endfunction

`ifdef MOUSE_ACCUM_EN
    function automatic logic signed [10:0] clamp11(input logic signed [11:0] v);
        if (v > 12'sd1023)       return 11'sd1023;
        else if (v < -12'sd1023) return -11'sd1023;
        else                     return v[10:0];
    endfunction
`endif

    logic              stra_q, stra_qq;
    logic              mouse_active_q, mouse_active_d;
    logic [1:0]        phase_q, phase_d;
    logic [3:0]        nib_q, nib_d;
    logic signed [10:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [7:0]        tx_x_q, tx_x_d, tx_y_q, tx_y_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [5:0]        port_o_q, port_o_d, port_oe_q, port_oe_d;

    logic              w_edge;
    logic signed [10:0] w_dx, w_dy;
    logic signed [10:0] w_base_x, w_base_y;
    logic [7:0]        w_sat_x, w_sat_y;
    logic [5:0]        w_joy_drv;
`ifdef MOUSE_ACCUM_EN
    logic signed [11:0] w_sum_x, w_sum_y;
`endif

    assign w_edge    = stra_q ^ stra_qq;
    // X is negated: host positive-right is MSX negative
    assign w_dx      = 11'sd0 - $signed({{2{mouse_x[8]}}, mouse_x});
    assign w_dy      = $signed({{2{mouse_y[8]}}, mouse_y});
    assign w_sat_x   = sat8(acc_x_q);
    assign w_sat_y   = sat8(acc_y_q);
    assign w_joy_drv = ~joy_in & {6{~stra}};

    always_comb begin
        mouse_active_d = mouse_active_q;
        phase_d        = phase_q;
        nib_d          = nib_q;
        acc_x_d        = acc_x_q;
        acc_y_d        = acc_y_q;
        tx_x_d         = tx_x_q;
        tx_y_d         = tx_y_q;
        tmo_d          = tmo_q;
        w_base_x       = acc_x_q;
        w_base_y       = acc_y_q;
`ifdef MOUSE_ACCUM_EN
        w_sum_x        = 12'sd0;
        w_sum_y        = 12'sd0;
`endif

        // A mouse report outranks a simultaneous joystick press
        if (mouse_strobe)
            mouse_active_d = 1'b1;
        else if (joy_in != 6'h3F)
            mouse_active_d = 1'b0;

        if (!mouse_active_d) begin
            phase_d = PH_XH;
            acc_x_d = '0;
            acc_y_d = '0;
            tmo_d   = '0;
        end else begin
            // An edge takes priority over the timeout expiring in the same cycle
            if (w_edge) begin
                phase_d = phase_q + 2'd1;
                tmo_d   = TMO_RELOAD;
                case (phase_q)
                    PH_XH: begin
                        tx_x_d   = w_sat_x;
                        tx_y_d   = w_sat_y;
                        nib_d    = w_sat_x[7:4];
                        w_base_x = '0;
                        w_base_y = '0;
                    end
                    PH_XL:   nib_d = tx_x_q[3:0];
                    PH_YH:   nib_d = tx_y_q[7:4];
                    PH_YL:   nib_d = tx_y_q[3:0];
                    default: nib_d = nib_q;
                endcase
            end else if (tmo_q == TMO_LAST) begin
                phase_d = PH_XH;
                tmo_d   = '0;
            end else if (tmo_q != '0) begin
                tmo_d = tmo_q - TMO_LAST;
            end

            // Base already reflects a phase-0 clear, so a coincident delta
            // lands in the fresh accumulators rather than being dropped
            acc_x_d = w_base_x;
            acc_y_d = w_base_y;
            if (mouse_strobe) begin
`ifdef MOUSE_ACCUM_EN
                w_sum_x = $signed({w_base_x[10], w_base_x}) + $signed({w_dx[10], w_dx});
                w_sum_y = $signed({w_base_y[10], w_base_y}) + $signed({w_dy[10], w_dy});
                acc_x_d = clamp11(w_sum_x);
                acc_y_d = clamp11(w_sum_y);
`else
                acc_x_d = w_dx;
                acc_y_d = w_dy;
`endif
            end
        end

        if (mouse_active_d) begin
            port_o_d  = {~mouse_flags, nib_d};
            port_oe_d = {mouse_flags, ~nib_d};
        end else begin
            port_o_d  = ~w_joy_drv;
            port_oe_d = w_joy_drv;
        end
    end

    always_ff @(posedge clk21m or negedge pSltRst_n) begin
        if (!pSltRst_n) begin
            stra_q         <= 1'b0;
            stra_qq        <= 1'b0;
            mouse_active_q <= 1'b0;
            phase_q        <= PH_XH;
            nib_q          <= 4'hF;
            acc_x_q        <= '0;
            acc_y_q        <= '0;
            tx_x_q         <= '0;
            tx_y_q         <= '0;
            tmo_q          <= '0;
            port_o_q       <= 6'h3F;
            port_oe_q      <= 6'h00;
        end else begin
            stra_q         <= stra;
            stra_qq        <= stra_q;
            mouse_active_q <= mouse_active_d;
            phase_q        <= phase_d;
            nib_q          <= nib_d;
            acc_x_q        <= acc_x_d;
            acc_y_q        <= acc_y_d;
            tx_x_q         <= tx_x_d;
            tx_y_q         <= tx_y_d;
            tmo_q          <= tmo_d;
            port_o_q       <= port_o_d;
            port_oe_q      <= port_oe_d;
        end
    end

    assign port_o       = port_o_q;
    assign port_oe      = port_oe_q;
    assign mouse_active = mouse_active_q;

endmodule
`default_nettype wire

// File: doc/msx_mouse_port_ctrl.md
# msx_mouse_port_ctrl

Sequencer and arbiter for MSX joystick port A. It shares the port between the host digital joystick and the host mouse, and it runs the MSX mouse nibble protocol on the port's strobe line. Movement from the host mouse is accumulated between MSX reads. The block sits between the MiST user_io mouse/joystick outputs and the emsx_top pJoyA/pStra pins; pin reordering and tri-state conversion stay in the top level.

## Interface
Parameters:
- TIMEOUT, 100000: idle clocks after the last strobe edge before the nibble phase returns to 0 (about 4.7 ms at 21.48 MHz); minimum 2.

Ports:
- clk21m  in  1  system clock
- pSltRst_n  in  1  asynchronous active-low reset
- joy_in  in  6  host joystick, active-low, [5:4] buttons, [3:0] directions
- mouse_x  in  9  host X delta, two's complement
- mouse_y  in  9  host Y delta, two's complement
- mouse_flags  in  2  host buttons, [0] left, [1] right, active-high
- mouse_strobe  in  1  one-clock pulse; new delta is valid on mouse_x/mouse_y
- stra  in  1  MSX port A strobe (pin 8), same clock domain
- port_o  out  6  pin level, [5:4] triggers, [3:0] nibble/directions
- port_oe  out  6  drive enable per bit; a bit is driven only when its level is 0
- mouse_active  out  1  1 = mouse mode

## Operation
- Mode arbitration, registered:
  - mouse_strobe sets mouse_active.
  - When mouse_strobe is low, any joy_in bit at 0 clears mouse_active.
  - If both occur in the same cycle, mouse_strobe wins.
- Leaving mouse mode forces phase to 0, clears the accumulators and clears the timeout.
- Joystick mode, per bit i:
  - port_o[i] = 0 and port_oe[i] = 1 when joy_in[i] = 0 and stra = 0.
  - Otherwise port_o[i] = 1 and port_oe[i] = 0.
- Mouse mode, bits [5:4]: port_o[5:4] = ~mouse_flags[1:0], registered every cycle.
- Mouse mode accumulation: on mouse_strobe, acc_x += -mouse_x and acc_y += mouse_y.
  - Both accumulators are 11-bit signed.
  - Each accumulator clamps at ±1023; it never wraps.
- Strobe edge: stra is registered into stra_q, then stra_d. An edge is stra_q ≠ stra_d. Each edge advances phase (2-bit, wraps 3→0), reloads the timeout counter with TIMEOUT, and loads nib:
  - Phase 0: tx_x = sat8(acc_x) and tx_y = sat8(acc_y), with sat8 clamping to [-128, 127]. Both accumulators clear in the same cycle. nib = tx_x[7:4].
    - A mouse_strobe in this same cycle contributes its delta to the freshly cleared accumulators; it is not lost.
  - Phase 1: nib = tx_x[3:0].
  - Phase 2: nib = tx_y[7:4].
  - Phase 3: nib = tx_y[3:0].
- Timeout: a nonzero counter decrements each cycle. The transition 1→0 forces phase to 0 and does not change nib.
- An edge in the same cycle as the 1→0 transition wins: the edge is processed using the pre-timeout phase.
- Mouse-mode nibble drive: port_o[3:0] = nib, and port_oe[3:0] = ~nib.

## Timing
- Reset values: port_o = 6'h3F, port_oe = 0, mouse_active = 0, phase = 0, nib = 4'hF, acc = 0, tx = 0, timeout = 0.
- stra change at edge N is seen as an edge at N+2; port_o shows the new nibble after edge N+2 (2-clock latency).
- Minimum stra half-period: 3 clocks. Faster toggling can merge edges; this is allowed and untested.
- Mode switch takes effect on port_o in the cycle after the triggering input.
- Joystick-mode outputs are registered: 1-clock latency from joy_in or stra.
- Assertion of pSltRst_n mid-sequence returns all state to reset values immediately; it is asynchronous.

## Configuration
- MOUSE_ACCUM_EN defined: accumulate-and-saturate behaviour as above.
- MOUSE_ACCUM_EN undefined: each mouse_strobe overwrites acc_x and acc_y with the new negated-X / Y delta (sign-extended). Deltas between reads are lost. Phase-0 latch and clear are unchanged.

## Test plan
- Reset, then idle: port_o = 3F, port_oe = 00, mouse_active = 0.
- Mouse strobe with x = +5, y = +3, then 4 stra toggles 4 clocks apart: nibbles F, B, 0, 3; each appears 2 clocks after its toggle.
- Three strobes of x = -100 (MOUSE_ACCUM_EN), then a read: tx_x = 7F, saturated. Without the macro: tx_x = 64.
- Two stra toggles, then TIMEOUT+2 idle clocks, then a toggle: nibble is tx_x[7:4] of a new latch, i.e. phase restarted.
- In mouse mode, joy_in = 3E (up pressed) with stra = 0: mouse_active = 0 next cycle, port_o = 3E, port_oe = 01, accumulators cleared.
- mouse_strobe coinciding with a phase-0 edge, x = -2: the current read uses the old accumulators; the next read reports tx_x = 02.
